// File: rtl/pinmux_cfg_loader.sv
// pinmux_cfg_loader
// Boot-time programmer for the pinmux select registers. A start pulse snapshots
// the per-peripheral input selects and per-pad output selects, packs them five
// 6-bit fields per 32-bit word, writes every word over TL-UL with PutFullData
// and, when Verify is set, reads each word back with Get and compares it.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   start_i            single-cycle start pulse (ignored while busy)
//   periph_insel_cfg_i desired input select per peripheral, field k at [6k+:6]
//   mio_outsel_cfg_i   desired output select per pad, field k at [6k+:6]
//   tl_h_o             TL-UL host request (tl_h2d_t layout, 102 bits)
//   tl_h_i             TL-UL device response (tl_d2h_t layout, 68 bits)
//   busy_o             sequence in progress
//   done_o             one-cycle pulse at the end of a sequence
//   err_o              sticky error for the last run (d_error or readback miss)
//   mismatch_cnt_o     readback mismatches in the last run, saturating at 15
module pinmux_cfg_loader #(
  parameter int          NPeriphIn      = 32,
  parameter int          NMioPads       = 32,
  parameter logic [31:0] BaseAddr       = 32'h4007_0000,
  parameter logic [31:0] PeriphInselOfs = 32'h04,
  parameter logic [31:0] MioOutselOfs   = 32'h20,
  parameter logic [7:0]  SourceId       = 8'h00,
  parameter bit          Verify         = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [6*NPeriphIn-1:0] periph_insel_cfg_i,
  input  logic [6*NMioPads-1:0]  mio_outsel_cfg_i,
  output logic [101:0]           tl_h_o,
  input  logic [67:0]            tl_h_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [3:0]             mismatch_cnt_o
);

  localparam int NWi  = (NPeriphIn + 4) / 5;
  localparam int NWo  = (NMioPads + 4) / 5;
  localparam int NW   = NWi + NWo;
  localparam int IdxW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrReq = 3'd1;
  localparam logic [2:0] StWrRsp = 3'd2;
  localparam logic [2:0] StRdReq = 3'd3;
  localparam logic [2:0] StRdRsp = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [6*NPeriphIn-1:0] insel_q, insel_d;
  logic [6*NMioPads-1:0]  outsel_q, outsel_d;
  logic                   err_q, err_d;
  logic [3:0]             cnt_q, cnt_d;

  logic [31:0] words [NW];
  logic [31:0] curWord;
  logic [31:0] curAddr;
  logic [31:0] idxExt;
  logic        aValid, isRead, lastWord;

  // Response fields of the tl_d2h_t vector that this host consumes.
  logic        dValid, dError, aReady;
  logic [31:0] dData;
  logic        unusedRsp;

  assign dValid    = tl_h_i[67];
  assign dData     = tl_h_i[49:18];
  assign dError    = tl_h_i[1];
  assign aReady    = tl_h_i[0];
  assign unusedRsp = ^{tl_h_i[66:50], tl_h_i[17:2]};

  // Pack the snapshot into register words; unused slots and bits [31:30] stay 0.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      words[w] = '0;
    end
    for (int k = 0; k < NPeriphIn; k++) begin
      words[k / 5][6 * (k % 5) +: 6] = insel_q[6 * k +: 6];
    end
    for (int k = 0; k < NMioPads; k++) begin
      words[NWi + k / 5][6 * (k % 5) +: 6] = outsel_q[6 * k +: 6];
    end
  end

  // Insel words occupy indices 0..NWi-1, outsel words follow.
  assign idxExt   = 32'(idx_q);
  assign curWord  = words[idx_q];
  assign curAddr  = (idxExt < NWi) ? (BaseAddr + PeriphInselOfs + (idxExt << 2))
                                   : (BaseAddr + MioOutselOfs + ((idxExt - NWi) << 2));
  assign lastWord = (idx_q == IdxW'(NW - 1));

  assign aValid = (state_q == StWrReq) || (state_q == StRdReq);
  assign isRead = (state_q == StRdReq);

  // Request fields are zeroed whenever no request is pending; d_ready is tied high.
  assign tl_h_o = {aValid,
                   aValid ? (isRead ? 3'd4 : 3'd0) : 3'd0,
                   3'd0,
                   aValid ? 2'd2 : 2'd0,
                   aValid ? SourceId : 8'h00,
                   aValid ? curAddr : 32'h0,
                   aValid ? 4'hF : 4'h0,
                   (aValid && !isRead) ? curWord : 32'h0,
                   16'h0,
                   1'b1};

  assign busy_o         = (state_q != StIdle) && (state_q != StDone);
  assign done_o         = (state_q == StDone);
  assign err_o          = err_q;
  assign mismatch_cnt_o = cnt_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    insel_d  = insel_q;
    outsel_d = outsel_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StWrReq;
          idx_d    = '0;
          insel_d  = periph_insel_cfg_i;
          outsel_d = mio_outsel_cfg_i;
          err_d    = 1'b0;
          cnt_d    = 4'd0;
        end
      end
      StWrReq: begin
        if (aReady) state_d = StWrRsp;
      end
      StWrRsp: begin
        if (dValid) begin
          if (dError) err_d = 1'b1;
          if (lastWord) begin
            idx_d   = '0;
            state_d = Verify ? StRdReq : StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        if (aReady) state_d = StRdRsp;
      end
      StRdRsp: begin
        if (dValid) begin
          // An errored response carries no trustworthy data, so it is not compared.
          if (dError) begin
            err_d = 1'b1;
          end else if (dData != curWord) begin
            err_d = 1'b1;
            if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          end
          if (lastWord) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      insel_q  <= '0;
      outsel_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      insel_q  <= insel_d;
      outsel_q <= outsel_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pinmux_cfg_loader.sv
// tb_pinmux_cfg_loader
// Directed bench for pinmux_cfg_loader. A behavioural TL-UL device answers
// requests with configurable a_ready delay, error injection and read
// corruption, and logs every write for comparison against hand-computed words.
module tb_pinmux_cfg_loader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [191:0] inselCfg;
  logic [191:0] outselCfg;
  logic [101:0] tlH;
  logic [67:0]  tlD;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   mmCnt;

  int checks = 0;
  int errors = 0;

  // Device model configuration and logs.
  int          readyDelay;
  int          errWrite;
  int          badRead0;
  int          badRead1;
  logic [31:0] wrAddr [$];
  logic [31:0] wrData [$];
  int          nWrites;
  int          nReads;
  int          protoErr;
  int          stabErr;
  int          earlyErr;
  logic [31:0] mem [14];

  logic [191:0] cfgA_in, cfgA_out, cfgB_in, cfgB_out;

  pinmux_cfg_loader dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .periph_insel_cfg_i (inselCfg),
    .mio_outsel_cfg_i   (outselCfg),
    .tl_h_o             (tlH),
    .tl_h_i             (tlD),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .mismatch_cnt_o     (mmCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent packing model: word w holds fields 5w..5w+4 of its bank.
  function automatic logic [31:0] modelWord(input logic [191:0] ins, input logic [191:0] outs,
                                            input int w);
    logic [31:0]  r;
    logic [191:0] src;
    int           base;
    r = '0;
    if (w < 7) begin
      src  = ins;
      base = w * 5;
    end else begin
      src  = outs;
      base = (w - 7) * 5;
    end
    for (int s = 0; s < 5; s++) begin
      if (base + s < 32) r[6*s +: 6] = src[6*(base+s) +: 6];
    end
    return r;
  endfunction

  // Device responder: decides a_ready / d_valid at each falling edge so the
  // DUT samples them on the next rising edge.
  initial begin : responder
    logic        pending;
    logic [31:0] respData;
    logic        respErr;
    int          waitCnt;
    logic        haveHold;
    logic [99:0] holdFields;
    logic [31:0] addr;
    int          idx;
    pending  = 1'b0;
    respData = '0;
    respErr  = 1'b0;
    waitCnt  = 0;
    haveHold = 1'b0;
    holdFields = '0;
    tlD = '0;
    forever begin
      @(negedge clk);
      tlD = '0;
      if (!rst_n) begin
        pending  = 1'b0;
        waitCnt  = 0;
        haveHold = 1'b0;
      end else if (pending) begin
        tlD[67]    = 1'b1;
        tlD[49:18] = respData;
        tlD[1]     = respErr;
        pending    = 1'b0;
        if (tlH[101]) earlyErr++;
      end else if (tlH[101]) begin
        if (!haveHold) begin
          holdFields = tlH[100:1];
          haveHold   = 1'b1;
        end else if (tlH[100:1] !== holdFields) begin
          stabErr++;
        end
        if (waitCnt < readyDelay) begin
          waitCnt++;
        end else begin
          tlD[0]   = 1'b1;
          waitCnt  = 0;
          haveHold = 1'b0;
          addr     = tlH[84:53];
          if (tlH[97:95] !== 3'd0 || tlH[94:93] !== 2'd2 || tlH[92:85] !== 8'h00 ||
              tlH[52:49] !== 4'hF || tlH[16:1] !== 16'h0 || tlH[0] !== 1'b1) protoErr++;
          if (addr >= 32'h4007_0020) idx = 7 + int'((addr - 32'h4007_0020) >> 2);
          else                       idx = int'((addr - 32'h4007_0004) >> 2);
          if (idx < 0 || idx > 13) begin
            protoErr++;
            idx = 0;
          end
          if (tlH[100:98] === 3'd0) begin
            wrAddr.push_back(addr);
            wrData.push_back(tlH[48:17]);
            mem[idx] = tlH[48:17];
            respErr  = (nWrites == errWrite);
            respData = '0;
            nWrites++;
          end else if (tlH[100:98] === 3'd4) begin
            if (tlH[48:17] !== 32'h0) protoErr++;
            respData = (nReads == badRead0 || nReads == badRead1) ? 32'h0 : mem[idx];
            respErr  = 1'b0;
            nReads++;
          end else begin
            protoErr++;
            respData = '0;
            respErr  = 1'b0;
          end
          pending = 1'b1;
        end
      end
    end
  end

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    nWrites    = 0;
    nReads     = 0;
    protoErr   = 0;
    stabErr    = 0;
    earlyErr   = 0;
    readyDelay = 0;
    errWrite   = -1;
    badRead0   = -1;
    badRead1   = -1;
  endtask

  task automatic resetDut();
    start     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start with the given config and count falling edges until done_o.
  // A second start with config B may be issued at cycle restartAt (0 = never).
  task automatic runSeq(input logic [191:0] ins, input logic [191:0] outs,
                        input int restartAt, output int cycles,
                        output logic vAt1, output logic bAt1);
    @(negedge clk);
    inselCfg  = ins;
    outselCfg = outs;
    start     = 1'b1;
    cycles    = 0;
    vAt1      = 1'b0;
    bAt1      = 1'b0;
    while (cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        vAt1 = tlH[101];
        bAt1 = busy;
      end
      start = (restartAt != 0 && cycles == restartAt);
      if (restartAt != 0 && cycles == restartAt) begin
        inselCfg  = cfgB_in;
        outselCfg = cfgB_out;
      end
      if (done) break;
    end
    start = 1'b0;
  endtask

  function automatic int countDataErrs(input logic [191:0] ins, input logic [191:0] outs);
    int n;
    n = 0;
    for (int w = 0; w < 14; w++) begin
      if (w >= wrData.size()) n++;
      else if (wrData[w] !== modelWord(ins, outs, w)) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    resetDut();
    checks++; if (tlH !== 102'h1) begin errors++; $display("[TB] FAIL reset_tl_h: got %0h expected %0h", tlH, 102'h1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
    checks++; if (mmCnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", mmCnt); end
  endtask

  task automatic test_write_verify();
    int   cyc;
    logic v1, b1;
    clearLog();
    runSeq(cfgA_in, cfgA_out, 0, cyc, v1, b1);
    checks++; if (v1 !== 1'b1) begin errors++; $display("[TB] FAIL wv_avalid_rise: got %0b expected 1", v1); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("[TB] FAIL wv_busy_rise: got %0b expected 1", b1); end
    checks++; if (cyc != 57) begin errors++; $display("[TB] FAIL wv_done_cycle: got %0d expected 57", cyc); end
    checks++; if (nWrites != 14) begin errors++; $display("[TB] FAIL wv_writes: got %0d expected 14", nWrites); end
    checks++; if (nReads != 14) begin errors++; $display("[TB] FAIL wv_reads: got %0d expected 14", nReads); end
    if (wrAddr.size() == 14) begin
      checks++; if (wrAddr[0] !== 32'h4007_0004) begin errors++; $display("[TB] FAIL wv_addr0: got %0h expected 40070004", wrAddr[0]); end
      checks++; if (wrData[0] !== 32'h040C_2040) begin errors++; $display("[TB] FAIL wv_data0: got %0h expected 040c2040", wrData[0]); end
      checks++; if (wrAddr[6] !== 32'h4007_001C) begin errors++; $display("[TB] FAIL wv_addr6: got %0h expected 4007001c", wrAddr[6]); end
      checks++; if (wrData[6] !== 32'h0000_07DE) begin errors++; $display("[TB] FAIL wv_data6: got %0h expected 000007de", wrData[6]); end
      checks++; if (wrAddr[7] !== 32'h4007_0020) begin errors++; $display("[TB] FAIL wv_addr7: got %0h expected 40070020", wrAddr[7]); end
      checks++; if (wrData[7] !== 32'h1B71_D79F) begin errors++; $display("[TB] FAIL wv_data7: got %0h expected 1b71d79f", wrData[7]); end
      checks++; if (wrAddr[13] !== 32'h4007_0038) begin errors++; $display("[TB] FAIL wv_addr13: got %0h expected 40070038", wrAddr[13]); end
      checks++; if (wrData[13] !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wv_data13: got %0h expected 00000001", wrData[13]); end
    end
    checks++; if (countDataErrs(cfgA_in, cfgA_out) != 0) begin errors++; $display("[TB] FAIL wv_all_data: got %0d bad words expected 0", countDataErrs(cfgA_in, cfgA_out)); end
    checks++; if (protoErr != 0) begin errors++; $display("[TB] FAIL wv_protocol: got %0d violations expected 0", protoErr); end
    checks++; if (earlyErr != 0) begin errors++; $display("[TB] FAIL wv_early_req: got %0d expected 0", earlyErr); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wv_err: got %0b expected 0", err); end
    checks++; if (mmCnt !== 4'd0) begin errors++; $display("[TB] FAIL wv_cnt: got %0d expected 0", mmCnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL wv_done_pulse_len: got %0b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wv_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic v1, b1;
    clearLog();
    readyDelay = 3;
    runSeq(cfgA_in, cfgA_out, 0, cyc, v1, b1);
    checks++; if (cyc != 141) begin errors++; $display("[TB] FAIL bp_done_cycle: got %0d expected 141", cyc); end
    checks++; if (stabErr != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", stabErr); end
    checks++; if (earlyErr != 0) begin errors++; $display("[TB] FAIL bp_early_req: got %0d expected 0", earlyErr); end
    checks++; if (nWrites != 14 || nReads != 14) begin errors++; $display("[TB] FAIL bp_count: got %0d/%0d expected 14/14", nWrites, nReads); end
    checks++; if (countDataErrs(cfgA_in, cfgA_out) != 0) begin errors++; $display("[TB] FAIL bp_data: got %0d bad words expected 0", countDataErrs(cfgA_in, cfgA_out)); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL bp_err: got %0b expected 0", err); end
  endtask

  task automatic test_mismatch();
    int   cyc;
    logic v1, b1;
    clearLog();
    badRead0 = 2;
    badRead1 = 9;
    runSeq(cfgA_in, cfgA_out, 0, cyc, v1, b1);
    checks++; if (cyc != 57) begin errors++; $display("[TB] FAIL mm_done_cycle: got %0d expected 57", cyc); end
    checks++; if (nWrites != 14 || nReads != 14) begin errors++; $display("[TB] FAIL mm_count: got %0d/%0d expected 14/14", nWrites, nReads); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL mm_err: got %0b expected 1", err); end
    checks++; if (mmCnt !== 4'd2) begin errors++; $display("[TB] FAIL mm_cnt: got %0d expected 2", mmCnt); end
  endtask

  task automatic test_derror();
    int   cyc;
    logic v1, b1;
    clearLog();
    errWrite = 5;
    runSeq(cfgA_in, cfgA_out, 0, cyc, v1, b1);
    checks++; if (cyc != 57) begin errors++; $display("[TB] FAIL de_done_cycle: got %0d expected 57", cyc); end
    checks++; if (nWrites != 14 || nReads != 14) begin errors++; $display("[TB] FAIL de_count: got %0d/%0d expected 14/14", nWrites, nReads); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL de_err: got %0b expected 1", err); end
    checks++; if (mmCnt !== 4'd0) begin errors++; $display("[TB] FAIL de_cnt: got %0d expected 0", mmCnt); end
  endtask

  task automatic test_start_while_busy();
    int   cyc;
    int   extraDone;
    logic v1, b1;
    clearLog();
    runSeq(cfgA_in, cfgA_out, 10, cyc, v1, b1);
    extraDone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checks++; if (cyc != 57) begin errors++; $display("[TB] FAIL sb_done_cycle: got %0d expected 57", cyc); end
    checks++; if (countDataErrs(cfgA_in, cfgA_out) != 0) begin errors++; $display("[TB] FAIL sb_data: got %0d bad words expected 0", countDataErrs(cfgA_in, cfgA_out)); end
    checks++; if (nWrites != 14 || nReads != 14) begin errors++; $display("[TB] FAIL sb_count: got %0d/%0d expected 14/14", nWrites, nReads); end
    checks++; if (extraDone != 0) begin errors++; $display("[TB] FAIL sb_extra_done: got %0d expected 0", extraDone); end
    checks++; if (err !== 1'b0 || mmCnt !== 4'd0) begin errors++; $display("[TB] FAIL sb_err: got %0b/%0d expected 0/0", err, mmCnt); end
  endtask

  task automatic test_reset_midseq();
    int   cyc;
    int   doneSeen;
    logic v1, b1;
    clearLog();
    @(negedge clk);
    inselCfg  = cfgA_in;
    outselCfg = cfgA_out;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 0;
    doneSeen  = 0;
    while (nWrites < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      if (done) doneSeen++;
    end
    checks++; if (nWrites != 4) begin errors++; $display("[TB] FAIL rm_reach_word3: got %0d writes expected 4", nWrites); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (tlH[101] !== 1'b0) begin errors++; $display("[TB] FAIL rm_avalid: got %0b expected 0", tlH[101]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %0b expected 0", busy); end
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL rm_no_done: got %0d pulses expected 0", doneSeen); end
    clearLog();
    runSeq(cfgA_in, cfgA_out, 0, cyc, v1, b1);
    checks++; if (cyc != 57) begin errors++; $display("[TB] FAIL rm_restart_cycle: got %0d expected 57", cyc); end
    checks++; if (wrAddr.size() == 0 || wrAddr[0] !== 32'h4007_0004) begin errors++; $display("[TB] FAIL rm_restart_addr0: got %0d writes expected first at 40070004", wrAddr.size()); end
    checks++; if (countDataErrs(cfgA_in, cfgA_out) != 0) begin errors++; $display("[TB] FAIL rm_restart_data: got %0d bad words expected 0", countDataErrs(cfgA_in, cfgA_out)); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      cfgA_in[6*k +: 6]  = 6'(k);
      cfgA_out[6*k +: 6] = 6'(31 - k);
      cfgB_in[6*k +: 6]  = 6'h3F;
      cfgB_out[6*k +: 6] = 6'h2A;
    end
    inselCfg  = '0;
    outselCfg = '0;
    start     = 1'b0;
    rst_n     = 1'b0;
    clearLog();
    test_reset();
    test_write_verify();
    test_backpressure();
    test_mismatch();
    test_derror();
    test_start_while_busy();
    test_reset_midseq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
